// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//  - ctrl_state_e : controller FSM state encoding (also visible on the debug
//                   'state' port, so the numeric values are fixed).
//  - OP_*         : opcode constants shared with the Datapath decoder.
//  - max_int      : small elaboration-time helper for sizing the timer.
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_RUN    = 3'd1,
    S_FLUSH  = 3'd2,
    S_MULDIV = 3'd3,
    S_HALT   = 3'd4
  } ctrl_state_e;

  localparam logic [3:0] OP_ALU  = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h1;
  localparam logic [3:0] OP_SW   = 4'h2;
  localparam logic [3:0] OP_BEQ  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_DIV  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ctrl_down_timer.sv
// Loadable down-counter with a zero flag. Used by the hazard controller to
// time both multi-cycle flushes and mul/div freezes.
// Ports:
//  clk      in  clock, rising edge
//  rst_n    in  asynchronous active-low clear (count -> 0)
//  load     in  load load_val this cycle (has priority over dec)
//  load_val in  W-bit value to load
//  dec      in  decrement by one; the count never wraps below zero
//  zero     out count is zero
module ctrl_down_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 16-bit pipelined Datapath. Produces
// PC and IF/ID enables, IF/ID flush, ID/EX bubble and ID/EX hold from the
// hazard inputs: load-use stalls, taken-branch flushes, mul/div freezes,
// halt, and a one-cycle fetch restart after reset.
// Ports:
//  clk, rst            clock; asynchronous active-low reset
//  id_valid/id_rs1/id_rs2  ID-stage instruction and its source registers
//  ex_memrd/ex_rd      EX-stage load flag and destination register
//  ex_muldiv_start     one-cycle pulse when a mul/div enters EX
//  branch_taken        branch resolved taken in EX
//  halt_req            halt instruction in EX
//  pc_write/ifid_write/flush/idex_bubble/idex_hold   pipeline controls
//  muldiv_busy/halted  status
//  state               current FSM state (debug)
//  stall_cnt           saturating count of stall/flush cycles
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REGW          = 4,
  parameter int MULDIV_CYCLES = 4,
  parameter int FLUSH_CYCLES  = 1,
  parameter int CNTW          = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic            ex_memrd,
  input  logic [REGW-1:0] ex_rd,
  input  logic            ex_muldiv_start,
  input  logic            branch_taken,
  input  logic            halt_req,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            flush,
  output logic            idex_bubble,
  output logic            idex_hold,
  output logic            muldiv_busy,
  output logic            halted,
  output logic [2:0]      state,
  output logic [CNTW-1:0] stall_cnt
);

  localparam int TW        = $clog2(max_int(MULDIV_CYCLES, FLUSH_CYCLES) + 1);
  // The entry cycle happens in S_RUN and the final cycle at timer==0, hence -2.
  localparam int FLUSH_LD  = (FLUSH_CYCLES >= 2) ? FLUSH_CYCLES - 2 : 0;
  localparam int MULDIV_LD = MULDIV_CYCLES - 2;

  ctrl_state_e     state_q, state_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]   tmr_val;
  logic            load_use, count_en;

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = id_valid && ex_memrd && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  ctrl_down_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    flush       = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    muldiv_busy = 1'b0;
    halted      = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tmr_dec     = 1'b0;
    case (state_q)
      S_INIT: begin
        flush       = 1'b1;
        idex_bubble = 1'b1;
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          flush       = 1'b1;
          idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d  = S_FLUSH;
            tmr_load = 1'b1;
            tmr_val  = TW'(FLUSH_LD);
          end
        end else if (halt_req) begin
          idex_bubble = 1'b1;
          state_d     = S_HALT;
        end else if (ex_muldiv_start) begin
          idex_hold   = 1'b1;
          muldiv_busy = 1'b1;
          state_d     = S_MULDIV;
          tmr_load    = 1'b1;
          tmr_val     = TW'(MULDIV_LD);
        end else if (load_use) begin
          // Single bubble: next cycle the load has moved on to MEM.
          idex_bubble = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      S_FLUSH: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        flush       = 1'b1;
        idex_bubble = 1'b1;
        if (tmr_zero) state_d = S_RUN;
        else          tmr_dec = 1'b1;
      end
      S_MULDIV: begin
        idex_hold   = 1'b1;
        muldiv_busy = 1'b1;
        if (tmr_zero) state_d = S_RUN;
        else          tmr_dec = 1'b1;
      end
      S_HALT: begin
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: begin
        flush       = 1'b1;
        idex_bubble = 1'b1;
        state_d     = S_INIT;
      end
    endcase
  end

  // Restart and halt cycles are not hazard cost, so they are not counted.
  assign count_en = (!pc_write || flush) &&
                    (state_q != S_INIT) && (state_q != S_HALT);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (count_en && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_INIT;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. Instance A uses the default
// parameters; instance B uses CNTW=4 and FLUSH_CYCLES=3 to exercise counter
// saturation and the multi-cycle flush state.
module tb_pipeline_hazard_ctrl;

  localparam int REGW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Hand-computed stall_cnt checkpoints for instance A, consumed in order.
  logic [15:0] exp_q[$];

  // Instance A signals
  logic            a_id_valid, a_ex_memrd, a_muldiv, a_branch, a_halt;
  logic [REGW-1:0] a_rs1, a_rs2, a_ex_rd;
  logic            a_pc_write, a_ifid_write, a_flush, a_bubble, a_hold, a_busy, a_halted;
  logic [2:0]      a_state;
  logic [15:0]     a_stall;

  // Instance B signals
  logic            b_id_valid, b_ex_memrd, b_muldiv, b_branch, b_halt;
  logic [REGW-1:0] b_rs1, b_rs2, b_ex_rd;
  logic            b_pc_write, b_ifid_write, b_flush, b_bubble, b_hold, b_busy, b_halted;
  logic [2:0]      b_state;
  logic [3:0]      b_stall;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REGW(REGW), .MULDIV_CYCLES(4), .FLUSH_CYCLES(1), .CNTW(16)) dut_a (
    .clk(clk), .rst(rst),
    .id_valid(a_id_valid), .id_rs1(a_rs1), .id_rs2(a_rs2),
    .ex_memrd(a_ex_memrd), .ex_rd(a_ex_rd), .ex_muldiv_start(a_muldiv),
    .branch_taken(a_branch), .halt_req(a_halt),
    .pc_write(a_pc_write), .ifid_write(a_ifid_write), .flush(a_flush),
    .idex_bubble(a_bubble), .idex_hold(a_hold), .muldiv_busy(a_busy),
    .halted(a_halted), .state(a_state), .stall_cnt(a_stall)
  );

  pipeline_hazard_ctrl #(.REGW(REGW), .MULDIV_CYCLES(4), .FLUSH_CYCLES(3), .CNTW(4)) dut_b (
    .clk(clk), .rst(rst),
    .id_valid(b_id_valid), .id_rs1(b_rs1), .id_rs2(b_rs2),
    .ex_memrd(b_ex_memrd), .ex_rd(b_ex_rd), .ex_muldiv_start(b_muldiv),
    .branch_taken(b_branch), .halt_req(b_halt),
    .pc_write(b_pc_write), .ifid_write(b_ifid_write), .flush(b_flush),
    .idex_bubble(b_bubble), .idex_hold(b_hold), .muldiv_busy(b_busy),
    .halted(b_halted), .state(b_state), .stall_cnt(b_stall)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_id_valid = 0; a_ex_memrd = 0; a_muldiv = 0; a_branch = 0; a_halt = 0;
    a_rs1 = '0; a_rs2 = '0; a_ex_rd = '0;
    b_id_valid = 0; b_ex_memrd = 0; b_muldiv = 0; b_branch = 0; b_halt = 0;
    b_rs1 = '0; b_rs2 = '0; b_ex_rd = '0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_a_stall(input string tag);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      check_eq(tag, 32'(a_stall), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    exp_q = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd7, 16'd8, 16'd8};
    idle_all();
    rst = 1'b0;
    repeat (3) step();
    check_eq("rst_pc_write", 32'(a_pc_write), 0);
    check_eq("rst_flush",    32'(a_flush), 1);
    check_eq("rst_bubble",   32'(a_bubble), 1);
    check_eq("rst_state",    32'(a_state), 0);
    check_eq("rst_stall",    32'(a_stall), 0);

    rst = 1'b1;
    #1;
    check_eq("init_flush",    32'(a_flush), 1);
    check_eq("init_pc_write", 32'(a_pc_write), 0);
    step();
    check_eq("run_pc_write",   32'(a_pc_write), 1);
    check_eq("run_ifid_write", 32'(a_ifid_write), 1);
    check_eq("run_flush",      32'(a_flush), 0);
    check_eq("run_state",      32'(a_state), 1);
    check_eq("run_stall",      32'(a_stall), 0);

    // Load-use on rs2
    a_id_valid = 1; a_ex_memrd = 1; a_ex_rd = 4'd3; a_rs2 = 4'd3;
    #1;
    check_eq("lu_pc_write",   32'(a_pc_write), 0);
    check_eq("lu_ifid_write", 32'(a_ifid_write), 0);
    check_eq("lu_bubble",     32'(a_bubble), 1);
    step();
    a_ex_memrd = 0;
    #1;
    check_eq("lu_after_pc_write", 32'(a_pc_write), 1);
    check_eq("lu_after_bubble",   32'(a_bubble), 0);
    check_a_stall("lu_stall");

    // Load to r0 never stalls
    a_ex_memrd = 1; a_ex_rd = 4'd0; a_rs1 = 4'd0; a_rs2 = 4'd0;
    #1;
    check_eq("r0_pc_write", 32'(a_pc_write), 1);
    check_eq("r0_bubble",   32'(a_bubble), 0);
    step();
    check_a_stall("r0_stall");

    // Load-use on rs1
    a_ex_rd = 4'd5; a_rs1 = 4'd5;
    #1;
    check_eq("lu1_pc_write", 32'(a_pc_write), 0);
    step();
    a_ex_memrd = 0;
    #1;
    check_a_stall("lu1_stall");

    // Load-use and taken branch together: branch wins
    a_ex_memrd = 1; a_ex_rd = 4'd3; a_rs2 = 4'd3; a_branch = 1;
    #1;
    check_eq("br_flush",    32'(a_flush), 1);
    check_eq("br_pc_write", 32'(a_pc_write), 1);
    check_eq("br_bubble",   32'(a_bubble), 1);
    step();
    a_branch = 0; a_ex_memrd = 0;
    #1;
    check_eq("br_after_state", 32'(a_state), 1);
    check_eq("br_after_flush", 32'(a_flush), 0);
    check_a_stall("br_stall");

    // Mul/div: 4-cycle freeze, branch ignored while frozen
    a_muldiv = 1;
    #1;
    check_eq("md_entry_hold", 32'(a_hold), 1);
    check_eq("md_entry_busy", 32'(a_busy), 1);
    check_eq("md_entry_pc",   32'(a_pc_write), 0);
    step();
    a_muldiv = 0; a_branch = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("md_hold",  32'(a_hold), 1);
      check_eq("md_busy",  32'(a_busy), 1);
      check_eq("md_flush", 32'(a_flush), 0);
      check_eq("md_state", 32'(a_state), 3);
      step();
    end
    a_branch = 0;
    #1;
    check_eq("md_done_hold",  32'(a_hold), 0);
    check_eq("md_done_state", 32'(a_state), 1);
    check_eq("md_done_pc",    32'(a_pc_write), 1);
    check_a_stall("md_stall");

    // Halt
    a_halt = 1;
    #1;
    check_eq("halt_entry_bubble", 32'(a_bubble), 1);
    check_eq("halt_entry_pc",     32'(a_pc_write), 0);
    check_eq("halt_entry_halted", 32'(a_halted), 0);
    step();
    a_halt = 0;
    #1;
    check_eq("halt_halted", 32'(a_halted), 1);
    check_eq("halt_state",  32'(a_state), 4);
    check_a_stall("halt_stall");
    for (int i = 0; i < 20; i++) begin
      a_id_valid = 1'($urandom_range(0, 1));
      a_ex_memrd = 1'($urandom_range(0, 1));
      a_muldiv   = 1'($urandom_range(0, 1));
      a_branch   = 1'($urandom_range(0, 1));
      a_halt     = 1'($urandom_range(0, 1));
      a_ex_rd    = REGW'($urandom_range(0, 15));
      a_rs1      = REGW'($urandom_range(0, 15));
      a_rs2      = a_ex_rd;
      #1;
      check_eq("halt_hold_halted", 32'(a_halted), 1);
      check_eq("halt_hold_pc",     32'(a_pc_write), 0);
      step();
    end
    check_eq("halt_hold_state", 32'(a_state), 4);
    check_a_stall("halt_hold_stall");
    idle_all();

    rst = 1'b0;
    #1;
    check_eq("halt_rst_state", 32'(a_state), 0);
    check_eq("halt_rst_stall", 32'(a_stall), 0);
    check_eq("halt_rst_flush", 32'(a_flush), 1);
    step();
    rst = 1'b1;
    step();
    check_eq("b_run_state", 32'(b_state), 1);

    // Instance B: 3-cycle flush
    b_branch = 1;
    #1;
    check_eq("b_br_flush", 32'(b_flush), 1);
    check_eq("b_br_pc",    32'(b_pc_write), 1);
    step();
    b_branch = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq("b_fl_state", 32'(b_state), 2);
      check_eq("b_fl_flush", 32'(b_flush), 1);
      check_eq("b_fl_pc",    32'(b_pc_write), 1);
      step();
    end
    check_eq("b_fl_done_state", 32'(b_state), 1);
    check_eq("b_fl_done_flush", 32'(b_flush), 0);
    check_eq("b_fl_stall",      32'(b_stall), 3);

    // Four mul/div ops (16 more stall cycles) saturate the 4-bit counter
    for (int k = 0; k < 4; k++) begin
      b_muldiv = 1;
      step();
      b_muldiv = 0;
      repeat (3) step();
      check_eq("b_md_state", 32'(b_state), 1);
      if (k == 0) check_eq("b_md_stall_first", 32'(b_stall), 7);
    end
    check_eq("b_sat_stall", 32'(b_stall), 15);
    b_id_valid = 1; b_ex_memrd = 1; b_ex_rd = 4'd7; b_rs1 = 4'd7;
    step();
    b_id_valid = 0; b_ex_memrd = 0;
    #1;
    check_eq("b_sat_hold", 32'(b_stall), 15);

    // Reset in the middle of a mul/div freeze
    b_muldiv = 1;
    step();
    b_muldiv = 0;
    #1;
    check_eq("b_mid_state", 32'(b_state), 3);
    check_eq("b_mid_hold",  32'(b_hold), 1);
    rst = 1'b0;
    #1;
    check_eq("b_rst_pc",     32'(b_pc_write), 0);
    check_eq("b_rst_ifid",   32'(b_ifid_write), 0);
    check_eq("b_rst_flush",  32'(b_flush), 1);
    check_eq("b_rst_bubble", 32'(b_bubble), 1);
    check_eq("b_rst_hold",   32'(b_hold), 0);
    check_eq("b_rst_busy",   32'(b_busy), 0);
    check_eq("b_rst_halted", 32'(b_halted), 0);
    check_eq("b_rst_state",  32'(b_state), 0);
    check_eq("b_rst_stall",  32'(b_stall), 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
